bhg_psg_vol_ramp: RTL and testbench

// - Multi-channel PSG volume stage: CHANNELS independent VOL_BITS volume targets, slewed one

---
 rtl/bhg_psg_pkg.sv | 36 +++
 rtl/bhg_vol_lut.sv | 31 +++
 rtl/bhg_psg_vol_ramp.sv | 185 ++++++++++++++++++
 tb/tb_bhg_psg_vol_ramp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bhg_psg_pkg.sv
// Shared PSG definitions: sweep FSM states and the dB-law volume table generator.
package bhg_psg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } psg_state_e;

    // Level for volume index i. Index 0 is silence and VMAX is full scale.
    // Index 1 is optionally half of index 2, which softens the first audible step.
    // The result is rounded to the nearest integer. Levels are never negative,
    // so adding 0.5 and truncating gives correct rounding.
    function automatic int vol_lut_val(input int  i,
                                       input int  vol_bits,
                                       input int  dac_bits,
                                       input real att_db,
                                       input int  soft_low);
        int  vmax;
        int  idx;
        real full;
        real lvl;
        vmax = (1 << vol_bits) - 1;
        full = real'((1 << dac_bits) - 1);
        if (i <= 0) begin
            return 0;
        end
        idx = ((i == 1) && (soft_low != 0) && (vmax >= 2)) ? 2 : i;
        lvl = (10.0 ** (real'(vmax - idx) * att_db / real'(vmax) / 20.0)) * full;
        if (idx != i) begin
            lvl = lvl / 2.0;
        end
        return $rtoi(lvl + 0.5);
    endfunction

endpackage

// File: rtl/bhg_vol_lut.sv
// Registered volume-to-level ROM. Its contents are fixed at elaboration from vol_lut_val.
module bhg_vol_lut
    import bhg_psg_pkg::*;
#(
    parameter int  VOL_BITS   = 5,
    parameter int  DAC_BITS   = 8,
    parameter real VOL_ATT_DB = -36.0,
    parameter int  SOFT_LOW   = 1
) (
    input  logic                clk,
    input  logic [VOL_BITS-1:0] i_addr,
    output logic [DAC_BITS-1:0] o_data
);

    localparam int DEPTH = 2 ** VOL_BITS;

    logic [DAC_BITS-1:0] w_rom [DEPTH];
    logic [DAC_BITS-1:0] r_data;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign w_rom[gi] = DAC_BITS'(vol_lut_val(gi, VOL_BITS, DAC_BITS, VOL_ATT_DB, SOFT_LOW));
    end

    // Registered read with one clock of latency, so the ROM maps onto a block-RAM style array.
    always_ff @(posedge clk) begin
        r_data <= w_rom[i_addr];
    end

    assign o_data = r_data;

endmodule

// File: rtl/bhg_psg_vol_ramp.sv
// Multi-channel PSG volume stage. Each sweep slews every channel toward its target,
// looks up the level, gates it by the tone bit, and publishes the per-channel levels and their sum.
module bhg_psg_vol_ramp
    import bhg_psg_pkg::*;
#(
    parameter int  CHANNELS   = 3,
    parameter int  VOL_BITS   = 5,
    parameter int  DAC_BITS   = 8,
    parameter real VOL_ATT_DB = -36.0,
    parameter int  RAMP_DIV   = 1,
    parameter int  SOFT_LOW   = 1,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int MIX_W      = DAC_BITS + $clog2(CHANNELS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         vol_we,
    input  logic [CH_W-1:0]              vol_ch,
    input  logic [VOL_BITS-1:0]          vol_din,
    input  logic                         tick,
    input  logic [CHANNELS-1:0]          tone,
    output logic                         busy,
    output logic [CHANNELS*DAC_BITS-1:0] dout,
    output logic [MIX_W-1:0]             mix_out,
    output logic                         dout_valid
);

    localparam int              RC_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    psg_state_e          r_state;
    psg_state_e          w_state_next;
    logic [CH_W-1:0]     r_ch;
    logic [RC_W-1:0]     r_ramp_cnt;
    logic                r_step_en;
    logic [VOL_BITS-1:0] r_tgt [CHANNELS];
    logic [VOL_BITS-1:0] r_cur [CHANNELS];
    logic [DAC_BITS-1:0] r_dout [CHANNELS];
    logic                r_rd_vld;
    logic [CH_W-1:0]     r_rd_ch;
    logic                r_rd_gate;
    logic [MIX_W-1:0]    r_acc;
    logic [MIX_W-1:0]    r_mix;
    logic                r_valid;

    logic                w_tick_acc;
    logic                w_addr_vld;
    logic                w_ramp_hit;
    logic [VOL_BITS-1:0] w_tgt_a;
    logic [VOL_BITS-1:0] w_cur_a;
    logic [VOL_BITS-1:0] w_cur_n;
    logic [DAC_BITS-1:0] w_lvl;
    logic [DAC_BITS-1:0] w_gated;
    logic [MIX_W-1:0]    w_sum;

    // A tick is accepted only when idle. Ticks that arrive while busy are dropped entirely.
    assign w_tick_acc = tick && (r_state == IDLE);
    assign w_addr_vld = (r_state == SWEEP);
    assign w_ramp_hit = (RAMP_DIV <= 1) ? 1'b1 : (r_ramp_cnt == RC_W'(RAMP_DIV - 1));

    // Compute the next FSM state and the busy flag.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (tick) w_state_next = SWEEP;
            end
            SWEEP: begin
                busy = 1'b1;
                if (r_ch == LAST_CH) w_state_next = DONE;
            end
            DONE: begin
                busy         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register, channel pointer, and ramp divider.
    // The step decision is latched once per accepted tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ch       <= '0;
            r_ramp_cnt <= '0;
            r_step_en  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_tick_acc) begin
                r_ch      <= '0;
                r_step_en <= (RAMP_DIV == 0) || w_ramp_hit;
                if (RAMP_DIV > 1) begin
                    r_ramp_cnt <= w_ramp_hit ? '0 : r_ramp_cnt + 1'b1;
                end
            end else if (w_addr_vld && (r_ch != LAST_CH)) begin
                r_ch <= r_ch + 1'b1;
            end
        end
    end

    // Slew the addressed channel by at most one index toward its target; without slew, jump to the target.
    always_comb begin
        w_tgt_a = r_tgt[r_ch];
        w_cur_a = r_cur[r_ch];
        w_cur_n = w_cur_a;
        if (r_step_en) begin
            if (RAMP_DIV == 0) begin
                w_cur_n = w_tgt_a;
            end else if (w_tgt_a > w_cur_a) begin
                w_cur_n = w_cur_a + 1'b1;
            end else if (w_tgt_a < w_cur_a) begin
                w_cur_n = w_cur_a - 1'b1;
            end
        end
    end

    bhg_vol_lut #(
        .VOL_BITS   (VOL_BITS),
        .DAC_BITS   (DAC_BITS),
        .VOL_ATT_DB (VOL_ATT_DB),
        .SOFT_LOW   (SOFT_LOW)
    ) u_lut (
        .clk    (clk),
        .i_addr (w_cur_n),
        .o_data (w_lvl)
    );

    // Carry the channel index and its tone gate alongside the ROM read.
    // The tone bit is sampled in the same cycle as the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld  <= 1'b0;
            r_rd_ch   <= '0;
            r_rd_gate <= 1'b0;
        end else begin
            r_rd_vld  <= w_addr_vld;
            r_rd_ch   <= r_ch;
            r_rd_gate <= tone[r_ch];
        end
    end

    assign w_gated = r_rd_gate ? w_lvl : '0;
    assign w_sum   = ((r_rd_ch == '0) ? '0 : r_acc) + MIX_W'(w_gated);

    // Per-channel state: target writes in any state, current-volume update in the address cycle,
    // and the output level in the ROM-return cycle.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_tgt[gi]  <= '0;
                r_cur[gi]  <= '0;
                r_dout[gi] <= '0;
            end else begin
                if (vol_we && (vol_ch == CH_W'(gi))) r_tgt[gi] <= vol_din;
                if (w_addr_vld && (r_ch == CH_W'(gi))) r_cur[gi] <= w_cur_n;
                if (r_rd_vld && (r_rd_ch == CH_W'(gi))) r_dout[gi] <= w_gated;
            end
        end
        assign dout[gi*DAC_BITS +: DAC_BITS] = r_dout[gi];
    end

    // Accumulate the sweep privately. Only the complete sum is published, together with dout_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mix   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_rd_vld) begin
                r_acc <= w_sum;
                if (r_rd_ch == LAST_CH) begin
                    r_mix   <= w_sum;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign mix_out    = r_mix;
    assign dout_valid = r_valid;

endmodule

// File: tb/tb_bhg_psg_vol_ramp.sv
// Directed bench for the PSG volume stage.
// Three instances share the same stimulus: u_dut0 has no slew, u_dut1 steps on every tick,
// and u_dut4 steps on every fourth tick.
module tb_bhg_psg_vol_ramp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vol_we = 1'b0;
    logic [1:0]  vol_ch = 2'd0;
    logic [4:0]  vol_din = 5'd0;
    logic        tick = 1'b0;
    logic [2:0]  tone = 3'b000;

    logic        b0, b1, b4;
    logic [23:0] d0, d1, d4;
    logic [9:0]  m0, m1, m4;
    logic        v0, v1, v4;

    int n_cmp = 0;
    int n_mis = 0;

    logic [4:0] lut_vol [6] = '{5'd31, 5'd30, 5'd16, 5'd2, 5'd1, 5'd0};
    int         lut_exp [6] = '{255, 223, 34, 5, 3, 0};
    int         div4_exp [8] = '{0, 0, 0, 3, 3, 3, 3, 5};

    always #5 clk = ~clk;

    bhg_psg_vol_ramp #(.RAMP_DIV(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .vol_we(vol_we), .vol_ch(vol_ch), .vol_din(vol_din),
        .tick(tick), .tone(tone), .busy(b0), .dout(d0), .mix_out(m0), .dout_valid(v0));
    bhg_psg_vol_ramp #(.RAMP_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .vol_we(vol_we), .vol_ch(vol_ch), .vol_din(vol_din),
        .tick(tick), .tone(tone), .busy(b1), .dout(d1), .mix_out(m1), .dout_valid(v1));
    bhg_psg_vol_ramp #(.RAMP_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .vol_we(vol_we), .vol_ch(vol_ch), .vol_din(vol_din),
        .tick(tick), .tone(tone), .busy(b4), .dout(d4), .mix_out(m4), .dout_valid(v4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lvl(input logic [23:0] d, input int k);
        return 32'(d[k*8 +: 8]);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [4:0] v);
        cyc();
        vol_we  = 1'b1;
        vol_ch  = ch;
        vol_din = v;
        cyc();
        vol_we = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!v0 && k < 10) begin
            cyc();
            k++;
        end
        if (!v0) check("sweep_timeout", 32'(v0), 32'd1);
        $display("sweep: d0=%h d1=%h d4=%h mix0=%0d mix1=%0d", d0, d1, d4, m0, m1);
    endtask

    // One accepted tick. When dbl is set, a second tick is sent while busy; it must be dropped.
    task automatic sweep(input bit dbl);
        cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        if (dbl) tick = 1'b1;
        cyc();
        tick = 1'b0;
        wait_valid();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int cur;
        int first;
        int nv;

        // Reset state.
        repeat (3) cyc();
        check("rst_dout", 32'(d1), 32'd0);
        check("rst_mix", 32'(m1), 32'd0);
        check("rst_valid", 32'(v1), 32'd0);
        check("rst_busy", 32'(b1), 32'd0);
        rst_n = 1'b1;
        cyc();

        // LUT dump through the no-slew instance.
        tone = 3'b111;
        for (int i = 0; i < 6; i++) begin
            wr(2'd0, lut_vol[i]);
            sweep(1'b0);
            check($sformatf("lut_%0d", lut_vol[i]), lvl(d0, 0), 32'(lut_exp[i]));
        end

        // Ramp up and down, one index per tick.
        do_reset();
        wr(2'd0, 5'd31);
        prev = 0;
        for (int t = 1; t <= 31; t++) begin
            sweep(1'b0);
            cur = int'(lvl(d1, 0));
            check("ramp_up_rise", 32'(cur > prev), 32'd1);
            if (t == 1)  check("ramp_up_t1", 32'(cur), 32'd3);
            if (t == 16) check("ramp_up_t16", 32'(cur), 32'd34);
            if (t == 30) check("ramp_up_t30", 32'(cur), 32'd223);
            if (t == 31) check("ramp_up_t31", 32'(cur), 32'd255);
            prev = cur;
        end
        wr(2'd0, 5'd0);
        for (int t = 1; t <= 31; t++) begin
            sweep(1'b0);
            cur = int'(lvl(d1, 0));
            check("ramp_dn_fall", 32'(cur < prev), 32'd1);
            if (t == 1)  check("ramp_dn_t1", 32'(cur), 32'd223);
            if (t == 15) check("ramp_dn_t15", 32'(cur), 32'd34);
            if (t == 29) check("ramp_dn_t29", 32'(cur), 32'd5);
            if (t == 31) check("ramp_dn_t31", 32'(cur), 32'd0);
            prev = cur;
        end
        sweep(1'b0);
        check("ramp_floor_hold", lvl(d1, 0), 32'd0);

        // Divide-by-4 ramp. The dropped busy ticks must not advance the divider.
        do_reset();
        wr(2'd0, 5'd31);
        for (int t = 0; t < 8; t++) begin
            sweep(1'b1);
            check($sformatf("div4_tick%0d", t + 1), lvl(d4, 0), 32'(div4_exp[t]));
        end

        // Gating and mix.
        do_reset();
        wr(2'd0, 5'd31);
        wr(2'd1, 5'd31);
        wr(2'd2, 5'd31);
        tone = 3'b101;
        sweep(1'b0);
        check("gate_ch0", lvl(d0, 0), 32'd255);
        check("gate_ch1", lvl(d0, 1), 32'd0);
        check("gate_ch2", lvl(d0, 2), 32'd255);
        check("mix_101", 32'(m0), 32'd510);
        tone = 3'b111;
        sweep(1'b0);
        check("mix_111", 32'(m0), 32'd765);

        // Timing: dout_valid exactly five cycles after the tick; a tick at T+2 is dropped.
        cyc();
        tick = 1'b1;
        first = -1;
        nv = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            tick = (c == 2);
            if (c == 1) check("busy_t1", 32'(b0), 32'd1);
            if (c == 5) check("busy_t5", 32'(b0), 32'd0);
            if (v0) begin
                nv++;
                if (first < 0) first = c;
            end
        end
        tick = 1'b0;
        check("valid_cycle", 32'(first), 32'd5);
        check("valid_count", 32'(nv), 32'd1);

        // A write that collides with the channel's address cycle applies on the next sweep.
        do_reset();
        wr(2'd1, 5'd5);
        sweep(1'b0);
        check("coll_pre", lvl(d1, 1), 32'd3);
        cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        vol_we  = 1'b1;
        vol_ch  = 2'd1;
        vol_din = 5'd0;
        cyc();
        vol_we = 1'b0;
        wait_valid();
        check("coll_old_tgt", lvl(d1, 1), 32'd5);
        sweep(1'b0);
        check("coll_new_tgt", lvl(d1, 1), 32'd3);

        // Channel index 3 does not exist and must be ignored.
        wr(2'd3, 5'd31);
        sweep(1'b0);
        check("ch3_dout", 32'(d0), 32'd0);
        check("ch3_mix", 32'(m0), 32'd0);

        // Reset in the middle of a sweep.
        wr(2'd0, 5'd31);
        sweep(1'b0);
        check("pre_rst", lvl(d0, 0), 32'd255);
        cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        check("midrst_dout", 32'(d0), 32'd0);
        check("midrst_mix", 32'(m0), 32'd0);
        check("midrst_busy", 32'(b0), 32'd0);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 1) rst_n = 1'b1;
            if (v0) nv++;
        end
        check("midrst_no_valid", 32'(nv), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
